move_exec_arbiter: RTL and testbench
====================================

# move_exec_arbiter

Shares one `move_executor` instance between two requesters: port 0 is the UI/player path and port 1 is the search engine. Each requester presents a (board, move) pair on a valid/ready handshake. The block grants requests round-robin, issues exactly one executor transaction at a time and waits for the registered result. It then returns the resulting board and capture flag to the granted requester on its own response handshake, with a watchdog that recovers from a missing executor result.

## Interface
- `EXEC_TIMEOUT`, default 15: cycles spent in WAIT without `exec_valid_in` before the request is abandoned.
- `clk_in`, in, 1: single clock, rising edge.
- `rst_in`, in, 1: reset, asynchronous and active-high.
- `req_valid_in`, in, 2: per-requester request valid.
- `req_ready_out`, out, 2: per-requester accept; at most one bit high.
- `req_move_in`, in, 2 x `move_t`: per-requester move.
- `req_board_in`, in, 2 x `board_t`: per-requester pre-move board.
- `rsp_valid_out`, out, 2: per-requester response valid; at most one bit high.
- `rsp_ready_in`, in, 2: per-requester response accept.
- `rsp_board_out`, out, `board_t`: post-move board (shared by both ports).
- `rsp_captured_out`, out, 1: the move captured a piece.
- `exec_valid_out`, out, 1: strobe to the executor's `valid_in`.
- `exec_move_out`, out, `move_t`: move sent to the executor.
- `exec_board_out`, out, `board_t`: board sent to the executor.
- `exec_valid_in`, in, 1: executor's `valid_out`.
- `exec_board_in`, in, `board_t`: executor's `board_out`.
- `exec_captured_in`, in, 1: executor's `captured_out`.
- `busy_out`, out, 1: state is not IDLE.
- `err_out`, out, 1: sticky; set on watchdog expiry, cleared only by reset.

## Operation
- **Registers:** state, grant (1b), last_grant (1b), wait counter (`$clog2(EXEC_TIMEOUT+1)` bits), latched move/board, latched result board/captured.
- **Arbitration (IDLE, combinational):**
  - If both requesters are valid, grant = ~last_grant. Otherwise grant = the one valid requester.
  - `req_ready_out[grant]` = 1 only in IDLE and only when `req_valid_in[grant]` is high.
- **IDLE → ISSUE** on handshake (valid & ready):
  - Latch `req_move_in[grant]` and `req_board_in[grant]` into `exec_move_out`/`exec_board_out`.
  - Store grant.
- **ISSUE:** `exec_valid_out`=1 for exactly this one cycle. Clear the counter. Go to WAIT.
- **WAIT:**
  - If `exec_valid_in`: latch `exec_board_in`→`rsp_board_out` and `exec_captured_in`→`rsp_captured_out`. Go to RESP.
  - Else if counter == `EXEC_TIMEOUT`: set `err_out`, set last_grant=grant, go to IDLE. No response is issued and the request is dropped.
  - Else counter += 1. The counter saturates and never wraps.
- **RESP:**
  - `rsp_valid_out[grant]`=1. Hold `rsp_board_out`/`rsp_captured_out` stable until the requester accepts.
  - On `rsp_ready_in[grant]`: last_grant=grant, go to IDLE.
  - The other port's `rsp_ready_in` is ignored.
- **Stray results:** `exec_valid_in` in IDLE, ISSUE or RESP is ignored and changes no register.
- **Request stability:** request inputs are sampled only at the handshake cycle. Changes afterwards have no effect. A requester may drop `req_valid_in` before being granted without consequence.
- **Reset (asynchronous, any state, including mid-transaction):**
  - state=IDLE, last_grant=1 (port 0 wins the first tie), counter=0.
  - `exec_valid_out`=0, `rsp_valid_out`=0, `busy_out`=0, `err_out`=0.
  - `rsp_board_out`, `rsp_captured_out`, `exec_move_out`, `exec_board_out` = 0.
  - A `req_ready_out` that depends on inputs in IDLE is permitted.
  - An executor result still in flight after reset is discarded (IDLE rule above).

## Timing
- Handshake at edge T (IDLE).
- ISSUE during T+1: `exec_valid_out`=1.
- The executor (1-cycle registered) returns `exec_valid_in` during T+2, in WAIT.
- `rsp_valid_out` is high from T+3.
- If `rsp_ready_in` is already high at T+3, the block is back in IDLE at T+4 and the next request can be accepted in T+4. Steady-state throughput is one move per 4 cycles.
- `busy_out` is high from T+1 until the IDLE cycle after the response (or after the timeout).
- Watchdog: with no executor reply, `err_out` rises EXEC_TIMEOUT+1 cycles after entering WAIT; it is registered and visible the following cycle.
- All outputs except `req_ready_out` are registered.

## Test plan
- **Single request:** start position, move e2→e4 on port 0 → `exec_valid_out` pulses once at T+1. `rsp_valid_out`=2'b01 at T+3 with ply incremented and en_passant={1,col 4}. `rsp_captured_out`=0. `req_ready_out[1]` is never high.
- **Round-robin:** both ports hold valid continuously with ready always high → grants alternate 0,1,0,1 (port 0 first after reset), one accept every 4 cycles.
- **Response backpressure:** hold `rsp_ready_in`=0 for 10 cycles → `rsp_valid_out` and `rsp_board_out` stay stable. Both `req_ready_out` bits stay 0 and a stray `exec_valid_in` pulse does not alter the held result.
- **Capture:** port 1 move whose destination holds an opponent piece → `rsp_captured_out`=1 and ply50=0 in `rsp_board_out`.
- **Watchdog:** disconnect the executor (`exec_valid_in`=0) with EXEC_TIMEOUT=15 → `err_out`=1 and the block returns to IDLE without any `rsp_valid_out`. The next request, from the other port, completes normally and `err_out` stays 1.
- **Reset mid-transaction:** assert `rst_in` asynchronously while in WAIT → all outputs go to their reset values immediately. The executor's late `exec_valid_in` is ignored, and port 0 is granted first on the next contended request.

Source files
------------

// File: rtl/move_exec_pkg.sv
// Board and move encodings shared by the move executor, its arbiter and their users.
package move_exec_pkg;

    // sq[i]: square i = rank*8 + file; 0 empty, [2:0] piece kind, [3] black.
    typedef struct packed {
        logic [63:0][3:0] sq;
        logic             stm;
        logic             ep_vld;
        logic [2:0]       ep_col;
        logic [6:0]       ply50;
        logic [9:0]       ply;
    } board_t;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
        logic [2:0] promo;
    } move_t;

endpackage

// File: rtl/move_exec_arbiter.sv
// Round-robin share of one move executor between two requesters; 4 cycles accept-to-accept when unstalled.
// One transaction in flight; requests stall while busy, the response is held until its port accepts.
module move_exec_arbiter
    import move_exec_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [1:0]        req_valid_in,
    output logic [1:0]        req_ready_out,
    input  move_t  [1:0]      req_move_in,
    input  board_t [1:0]      req_board_in,
    output logic [1:0]        rsp_valid_out,
    input  logic [1:0]        rsp_ready_in,
    output board_t            rsp_board_out,
    output logic              rsp_captured_out,
    output logic              exec_valid_out,
    output move_t             exec_move_out,
    output board_t            exec_board_out,
    input  logic              exec_valid_in,
    input  board_t            exec_board_in,
    input  logic              exec_captured_in,
    output logic              busy_out,
    output logic              err_out
);

    localparam int CW = (EXEC_TIMEOUT > 0) ? $clog2(EXEC_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(EXEC_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant;
    logic          last_grant;
    logic          arb_grant;
    logic          accept;
    logic          timeout;
    logic          rsp_done;
    logic [CW-1:0] cnt;

    always_comb begin
        state_nxt     = state;
        req_ready_out = 2'b00;
        accept        = 1'b0;
        timeout       = 1'b0;
        rsp_done      = 1'b0;
        // On a tie the port that was not served last wins.
        arb_grant     = (req_valid_in == 2'b11) ? ~last_grant : req_valid_in[1];
        case (state)
            IDLE: begin
                req_ready_out[arb_grant] = req_valid_in[arb_grant];
                accept = req_valid_in[arb_grant];
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (exec_valid_in) begin
                    state_nxt = RESP;
                end else if (cnt == TMO) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_in[grant]) begin
                    state_nxt = IDLE;
                    rsp_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grant            <= 1'b0;
            last_grant       <= 1'b1;
            cnt              <= '0;
            exec_move_out    <= '0;
            exec_board_out   <= '0;
            rsp_board_out    <= '0;
            rsp_captured_out <= 1'b0;
            err_out          <= 1'b0;
        end else begin
            if (accept) begin
                grant          <= arb_grant;
                exec_move_out  <= req_move_in[arb_grant];
                exec_board_out <= req_board_in[arb_grant];
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT && !exec_valid_in && cnt != TMO) begin
                cnt <= cnt + CW'(1);
            end
            // Results outside WAIT are strays from an abandoned or pre-reset transaction.
            if (state == WAIT && exec_valid_in) begin
                rsp_board_out    <= exec_board_in;
                rsp_captured_out <= exec_captured_in;
            end
            if (timeout) err_out <= 1'b1;
            if (timeout || rsp_done) last_grant <= grant;
        end
    end

    assign exec_valid_out = (state == ISSUE);
    assign busy_out       = (state != IDLE);
    assign rsp_valid_out  = {(state == RESP) && grant, (state == RESP) && !grant};

endmodule

// File: tb/tb_move_exec_arbiter.sv
// Directed bench for move_exec_arbiter with a 1-cycle behavioural executor attached.
module tb_move_exec_arbiter;
    import move_exec_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    move_t  [1:0] req_move = '0;
    board_t [1:0] req_board = '0;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready = 2'b00;
    board_t       rsp_board;
    logic         rsp_captured;
    logic         exec_valid;
    move_t        exec_move;
    board_t       exec_board;
    logic         exec_valid_ret;
    board_t       exec_board_ret;
    logic         exec_captured_ret;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    move_exec_arbiter #(.EXEC_TIMEOUT(15)) dut (
        .clk_in(clk), .rst_in(rst),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_move_in(req_move), .req_board_in(req_board),
        .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
        .rsp_board_out(rsp_board), .rsp_captured_out(rsp_captured),
        .exec_valid_out(exec_valid), .exec_move_out(exec_move), .exec_board_out(exec_board),
        .exec_valid_in(exec_valid_ret), .exec_board_in(exec_board_ret),
        .exec_captured_in(exec_captured_ret),
        .busy_out(busy), .err_out(err)
    );

    function automatic board_t exec_move_fn(board_t b, move_t m);
        board_t     nb;
        logic [3:0] pc;
        nb = b;
        pc = b.sq[m.src];
        nb.sq[m.dst] = pc;
        nb.sq[m.src] = 4'd0;
        nb.stm       = ~b.stm;
        nb.ply       = b.ply + 10'd1;
        nb.ep_vld    = (pc[2:0] == 3'd1) &&
                       ((int'(m.dst) - int'(m.src) == 16) || (int'(m.src) - int'(m.dst) == 16));
        nb.ep_col    = nb.ep_vld ? m.dst[2:0] : 3'd0;
        nb.ply50     = (b.sq[m.dst] != 4'd0 || pc[2:0] == 3'd1) ? 7'd0 : b.ply50 + 7'd1;
        return nb;
    endfunction

    // Behavioural executor: one registered cycle, can be disconnected, plus a stray-pulse injector.
    logic   ex_en    = 1'b1;
    logic   stray    = 1'b0;
    logic   ex_vld_q = 1'b0;
    logic   ex_cap_q = 1'b0;
    board_t ex_brd_q = '0;
    board_t junk;
    assign junk = '1;

    always @(posedge clk) begin
        ex_vld_q <= exec_valid & ex_en;
        if (exec_valid) begin
            ex_brd_q <= exec_move_fn(exec_board, exec_move);
            ex_cap_q <= (exec_board.sq[exec_move.dst] != 4'd0);
        end
    end

    assign exec_valid_ret    = ex_vld_q | stray;
    assign exec_board_ret    = stray ? junk : ex_brd_q;
    assign exec_captured_ret = stray ? 1'b1 : ex_cap_q;

    function automatic board_t start_board();
        board_t     b;
        logic [3:0] back [8];
        back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b.sq[c]      = back[c];
            b.sq[8 + c]  = 4'd1;
            b.sq[48 + c] = 4'd9;
            b.sq[56 + c] = back[c] | 4'd8;
        end
        return b;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int   cyc = 0;
    logic rdy1_seen = 1'b0;
    logic rsp_seen = 1'b0;
    int   pulses = 0;
    int   acc_port[$];
    int   acc_cyc[$];

    // Records the handshake about to happen at the next rising edge, then samples at the falling edge.
    task automatic tick();
        #1;
        if ((req_valid & req_ready) != 2'b00) begin
            acc_port.push_back(int'(req_ready[1]));
            acc_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
        if (req_ready[1]) rdy1_seen = 1'b1;
        if (rsp_valid != 2'b00) rsp_seen = 1'b1;
        if (exec_valid) pulses++;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] exp);
        int n;
        n = 0;
        while (rsp_valid != exp && n < 40) begin
            tick();
            n++;
        end
        chk(tag, rsp_valid, exp);
    endtask

    move_t  e2e4;
    move_t  e7e5;
    move_t  nxf3;
    board_t sb;
    board_t rb;
    board_t cb;
    board_t held;

    initial begin
        sb   = start_board();
        e2e4 = '{src: 6'd12, dst: 6'd28, promo: 3'd0};
        e7e5 = '{src: 6'd52, dst: 6'd36, promo: 3'd0};
        nxf3 = '{src: 6'd6,  dst: 6'd21, promo: 3'd0};
        rb   = exec_move_fn(sb, e2e4);
        cb   = '0;
        cb.sq[4]  = 4'd6;
        cb.sq[60] = 4'd14;
        cb.sq[6]  = 4'd2;
        cb.sq[21] = 4'd9;
        cb.ply50  = 7'd5;
        cb.ply    = 10'd20;

        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_board_zero", rsp_board == '0, 1);
        chk("rst_exec_board_zero", exec_board == '0, 1);
        rst = 1'b0;
        tick();

        // Single request on port 0: e2-e4 from the start position.
        rdy1_seen = 1'b0; pulses = 0;
        req_board[0] = sb; req_move[0] = e2e4; req_valid = 2'b01;
        #1 chk("t1_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; req_move[0] = '0; req_board[0] = '0;
        chk("t1_issue_valid", exec_valid, 1);
        chk("t1_issue_move", {exec_move.src, exec_move.dst}, {6'd12, 6'd28});
        chk("t1_issue_board", exec_board == sb, 1);
        tick();
        chk("t1_wait_exec_valid", exec_valid, 0);
        chk("t1_wait_busy", busy, 1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_ply", rsp_board.ply, 1);
        chk("t1_ep", {rsp_board.ep_vld, rsp_board.ep_col}, {1'b1, 3'd4});
        chk("t1_captured", rsp_captured, 0);
        chk("t1_sq_e4", rsp_board.sq[28], 1);
        chk("t1_sq_e2", rsp_board.sq[12], 0);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("t1_done_rsp_valid", rsp_valid, 0);
        chk("t1_done_busy", busy, 0);
        chk("t1_pulses", pulses, 1);
        chk("t1_ready1_never", rdy1_seen, 0);

        // Round robin after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        acc_port.delete(); acc_cyc.delete();
        req_board[0] = sb; req_move[0] = e2e4;
        req_board[1] = rb; req_move[1] = e7e5;
        req_valid = 2'b11; rsp_ready = 2'b11;
        repeat (18) tick();
        req_valid = 2'b00;
        repeat (6) tick();
        rsp_ready = 2'b00;
        chk("t2_accepts_ge4", acc_port.size() >= 4, 1);
        for (int i = 0; i < 4 && i < acc_port.size(); i++) begin
            chk($sformatf("t2_grant%0d", i), acc_port[i], i % 2);
            if (i > 0) chk($sformatf("t2_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);
        end
        chk("t2_idle", busy, 0);

        // Response backpressure with a stray executor pulse.
        req_board[0] = sb; req_move[0] = e2e4; req_valid = 2'b01;
        tick();
        req_valid = 2'b11;
        wait_rsp("t3_rsp", 2'b01);
        held = rsp_board;
        rsp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            stray = (i == 4);
            tick();
            chk($sformatf("t3_valid%0d", i), rsp_valid, 2'b01);
            chk($sformatf("t3_board%0d", i), rsp_board == held, 1);
            chk($sformatf("t3_ready%0d", i), req_ready, 2'b00);
        end
        stray = 1'b0;
        chk("t3_captured_held", rsp_captured, 0);
        req_valid = 2'b00; rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        chk("t3_done", busy, 0);

        // Capture on port 1.
        req_board[1] = cb; req_move[1] = nxf3; req_valid = 2'b10;
        #1 chk("t4_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        wait_rsp("t4_rsp", 2'b10);
        chk("t4_captured", rsp_captured, 1);
        chk("t4_ply50", rsp_board.ply50, 0);
        chk("t4_ply", rsp_board.ply, 21);
        chk("t4_sq_f3", rsp_board.sq[21], 2);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Watchdog with the executor disconnected.
        ex_en = 1'b0; rsp_seen = 1'b0;
        req_board[0] = sb; req_move[0] = e2e4; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 16; k++) tick();
        chk("t5_err_before", err, 0);
        chk("t5_busy_before", busy, 1);
        tick();
        chk("t5_err_after", err, 1);
        chk("t5_idle_after", busy, 0);
        chk("t5_no_rsp", rsp_seen, 0);
        ex_en = 1'b1;
        req_board[1] = cb; req_move[1] = nxf3; req_valid = 2'b10;
        #1 chk("t5_next_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        wait_rsp("t5_next_rsp", 2'b10);
        chk("t5_next_captured", rsp_captured, 1);
        chk("t5_err_sticky", err, 1);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // Reset in WAIT after port 0 was served last.
        req_board[0] = sb; req_move[0] = e2e4; req_valid = 2'b01; rsp_ready = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (4) tick();
        rsp_ready = 2'b00;
        chk("t6_pre_idle", busy, 0);
        ex_en = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("t6_in_wait", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_exec_valid", exec_valid, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_rsp_board", rsp_board == '0, 1);
        chk("t6_rst_captured", rsp_captured, 0);
        chk("t6_rst_exec_board", exec_board == '0, 1);
        chk("t6_rst_exec_move", exec_move, 0);
        tick();
        rst = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();
        chk("t6_late_board", rsp_board == '0, 1);
        chk("t6_late_busy", busy, 0);
        chk("t6_late_rsp", rsp_valid, 0);
        ex_en = 1'b1;
        req_board[0] = sb; req_board[1] = rb; req_move[0] = e2e4; req_move[1] = e7e5;
        req_valid = 2'b11;
        #1 chk("t6_tie_port0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; rsp_ready = 2'b11;
        wait_rsp("t6_rsp", 2'b01);
        tick();
        rsp_ready = 2'b00;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
